pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
// - Multi-mode, parametrised pipelined barrel shifter for the fixp_acc datapath (box_250mhz).
// - Replaces the fixed left-only shifter with four modes: LSL, LSR, ASR and ROL.
// - Adds a sticky (shifted-out) flag for rounding, sideband passthrough and full valid/ready backpressure with bubble collapse.
// PARAMETERS
// - DATA_W     128  data width; power of 2, >= 2.
// - USER_W     8    sideband width, carried unchanged alongside the data; >= 1.
// - REG_EVERY  1    combinational shift levels per register stage; 1..NL.
// - Derived: SHAMT_W = $clog2(DATA_W)+1.
// - Derived: NL = SHAMT_W (number of shift levels).
// - Derived: NS = ceil(NL/REG_EVERY) (register stages = latency in cycles).
// PORTS
// - clk       in   1        clock; single clock domain.
// - rst       in   1        synchronous, active-high reset.
// - s_tvalid  in   1        input beat valid.
// - s_tready  out  1        input beat accepted when s_tvalid & s_tready.
// - s_tdata   in   DATA_W   operand.
// - s_shamt   in   SHAMT_W  shift amount, unsigned; range 0..2*DATA_W-1.
// - s_mode    in   2        00 LSL, 01 LSR, 10 ASR, 11 ROL.
// - s_tuser   in   USER_W   sideband, passed through unchanged.
// - m_tvalid  out  1        result valid.
// - m_tready  in   1        downstream ready.
// - m_tdata   out  DATA_W   shifted result.
// - m_sticky  out  1        OR of all 1-bits discarded by the shift.
// - m_tuser   out  USER_W   sideband of the same beat.
// BEHAVIOUR
// - Reset: all stage valids clear; m_tvalid=0, m_tdata=0, m_sticky=0, m_tuser=0.
// - After reset is released, s_tready=1 on the first cycle.
// - Levels k=0..NL-2: shift by 2^k when shamt[k]=1.
// - Level NL-1 is the overflow level, active when shamt[SHAMT_W-1]=1:
//   - LSL/LSR: result becomes 0.
//   - ASR: result becomes all copies of the original sign bit.
//   - ROL: no effect, i.e. the amount is taken mod DATA_W.
// - Fill rules: LSL and LSR fill with 0; ASR fills with the operand MSB captured at input; ROL reinserts the bits that leave.
// - Sticky accumulates across levels:
//   - LSL: bits leaving past the MSB.
//   - LSR/ASR: bits leaving past the LSB.
//   - ROL: sticky is always 0.
// - ASR sign bits discarded on the right count as shifted-out bits.
// - Each register stage holds: data, remaining shamt, mode, sign, sticky, user, valid.
// - Register boundaries follow every REG_EVERY levels; the last stage drives the m_* ports directly (registered outputs).
// - Latency is exactly NS cycles from accept to m_tvalid when no backpressure occurs. NS=8 for defaults.
// - Throughput: 1 beat/cycle.
// - Handshake, per stage i:
//   - rdy_i = ~v_i | rdy_{i+1}, with rdy_NS = m_tready.
//   - s_tready = rdy_1 (first stage).
//   - A stage loads when rdy_i; otherwise it holds all its fields.
//   - Bubbles collapse: an empty stage accepts even while m_tready=0.
// - m_tvalid, m_tdata, m_sticky and m_tuser stay stable while m_tvalid & ~m_tready (AXI-Stream rule).
// - The ready chain is combinational across NS stages; this is acceptable for NS <= 8.
// - Pipeline full with m_tready=0: s_tready=0 and no beat is lost or duplicated.
// - Simultaneous output and input handshake on a full pipe: every stage advances and occupancy is unchanged.
// - shamt=0: data passes unchanged and sticky=0 in all modes.
// - Reset mid-operation: all in-flight beats are dropped, with no partial output afterwards.
// - Beats leave in the order they arrived; mode and shamt apply per beat.
// TESTING
// - DATA_W=128: LSL, shamt=4, data=0xF000...0001 -> 0x0000...0010, sticky=1, after exactly 8 cycles.
// - LSR, shamt=1, data=0x...0003 -> 0x...0001, sticky=1.
// - ASR, shamt=200, data MSB=1 -> all-ones, sticky=1.
// - ASR, shamt=200, data=0 -> 0, sticky=0.
// - ROL, shamt=129, data=0x8000...0000 -> 0x...0001, sticky=0.
// - Stream 16 random beats back-to-back with m_tready toggling 1010..., compare against a reference model:
//   - results match in order;
//   - user tags are preserved;
//   - outputs are stable while stalled.
// - Hold m_tready=0 and fill the pipe -> s_tready falls after exactly NS accepts.
// - Then assert m_tready=1 for 1 cycle -> s_tready=1 in the same cycle.
// - Assert rst with 5 beats in flight -> m_tvalid=0 on the next cycle, and no stale beats emerge after release.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Stream bundle for the pipelined barrel shifter: upstream (s_*) and downstream (m_*) handshakes.
// The master modport is the environment side; the slave modport is the shifter itself.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned USER_W = 8
);
  localparam int unsigned SHAMT_W = $clog2(DATA_W) + 1;

  logic               s_tvalid;
  logic               s_tready;
  logic [DATA_W-1:0]  s_tdata;
  logic [SHAMT_W-1:0] s_shamt;
  logic [1:0]         s_mode;
  logic [USER_W-1:0]  s_tuser;
  logic               m_tvalid;
  logic               m_tready;
  logic [DATA_W-1:0]  m_tdata;
  logic               m_sticky;
  logic [USER_W-1:0]  m_tuser;

  modport master (
    output s_tvalid, s_tdata, s_shamt, s_mode, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_sticky, m_tuser
  );

  modport slave (
    input  s_tvalid, s_tdata, s_shamt, s_mode, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_sticky, m_tuser
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode (LSL/LSR/ASR/ROL) pipelined barrel shifter with sticky flag, sideband passthrough
// and per-stage valid/ready backpressure that collapses bubbles.
module pipelined_barrel_shifter #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned USER_W    = 8,
  parameter int unsigned REG_EVERY = 1
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(DATA_W) + 1;
  localparam int unsigned NL      = SHAMT_W;
  localparam int unsigned NS      = (NL + REG_EVERY - 1) / REG_EVERY;

  typedef enum logic [1:0] {
    ModeLsl = 2'b00,
    ModeLsr = 2'b01,
    ModeAsr = 2'b10,
    ModeRol = 2'b11
  } mode_e;

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    mode_e              mode;
    logic               sign;
    logic               sticky;
    logic [USER_W-1:0]  user;
  } stage_t;

  stage_t          st_q [NS];
  stage_t          st_d [NS];
  stage_t          in_beat;
  logic [NS-1:0]   rdy;

  // One shift level; the top level handles amounts >= DATA_W (ROL wraps, so it is a no-op).
  function automatic stage_t apply_level(stage_t st, int unsigned k);
    stage_t             r;
    logic [DATA_W-1:0]  ones;
    logic [DATA_W-1:0]  lost;
    logic [SHAMT_W-1:0] sel;
    int unsigned        amt;
    r    = st;
    ones = '1;
    lost = '0;
    sel  = SHAMT_W'(1) << k;
    amt  = 32'd1 << k;
    if ((st.shamt & sel) != '0) begin
      if (k == NL - 1) begin
        if (st.mode != ModeRol) begin
          lost   = st.data;
          r.data = (st.mode == ModeAsr) ? {DATA_W{st.sign}} : '0;
        end
      end else begin
        unique case (st.mode)
          ModeLsl: begin
            r.data = st.data << amt;
            lost   = st.data & ~(ones >> amt);
          end
          ModeLsr: begin
            r.data = st.data >> amt;
            lost   = st.data & ~(ones << amt);
          end
          ModeAsr: begin
            r.data = (st.data >> amt) | ({DATA_W{st.sign}} & ~(ones >> amt));
            lost   = st.data & ~(ones << amt);
          end
          ModeRol: begin
            r.data = (st.data << amt) | (st.data >> (DATA_W - amt));
          end
        endcase
      end
      r.shamt  = st.shamt & ~sel;
      r.sticky = st.sticky | (|lost);
    end
    return r;
  endfunction

  always_comb begin
    in_beat.valid  = bus.s_tvalid;
    in_beat.data   = bus.s_tdata;
    in_beat.shamt  = bus.s_shamt;
    in_beat.mode   = mode_e'(bus.s_mode);
    in_beat.sign   = bus.s_tdata[DATA_W-1];
    in_beat.sticky = 1'b0;
    in_beat.user   = bus.s_tuser;

    st_d[0] = in_beat;
    for (int unsigned s = 1; s < NS; s++) begin
      st_d[s] = st_q[s-1];
    end
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned k = 0; k < NL; k++) begin
        if (k / REG_EVERY == s) st_d[s] = apply_level(st_d[s], k);
      end
    end
  end

  // A stage may load when it, or any stage downstream of it, is empty, or the sink is ready.
  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
      rdy[s] = bus.m_tready;
      for (int unsigned j = s; j < NS; j++) begin
        rdy[s] = rdy[s] | ~st_q[j].valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NS; s++) begin
        st_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        if (rdy[s]) st_q[s] <= st_d[s];
      end
    end
  end

  assign bus.s_tready = rdy[0];
  assign bus.m_tvalid = st_q[NS-1].valid;
  assign bus.m_tdata  = st_q[NS-1].data;
  assign bus.m_sticky = st_q[NS-1].sticky;
  assign bus.m_tuser  = st_q[NS-1].user;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: arithmetic reference model plus scoreboard,
// directed vectors with literal expectations, backpressure, fill and mid-flight reset scenarios.
module tb_pipelined_barrel_shifter;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned USER_W = 8;
  localparam int unsigned NS     = 8;

  typedef struct {
    logic [127:0] data;
    logic         sticky;
    logic [7:0]   user;
    logic         has_lit;
    logic [127:0] lit_data;
    logic         lit_sticky;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.DATA_W(DATA_W), .USER_W(USER_W)) bus ();

  pipelined_barrel_shifter #(
    .DATA_W   (DATA_W),
    .USER_W   (USER_W),
    .REG_EVERY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_out = 0;
  exp_t sb[$];

  logic         toggle = 1'b0;
  logic         cur_has_lit = 1'b0;
  logic [127:0] cur_lit_data = '0;
  logic         cur_lit_sticky = 1'b0;

  logic         prev_stall = 1'b0;
  logic         held_valid;
  logic [127:0] held_data;
  logic         held_sticky;
  logic [7:0]   held_user;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: whole-amount arithmetic on the full operand.
  function automatic void ref_shift(input logic [127:0] d, input logic [7:0] sh,
                                    input logic [1:0] md, output logic [127:0] r,
                                    output logic st);
    int unsigned n;
    int unsigned m;
    n = sh;
    m = n % 128;
    r = '0;
    st = 1'b0;
    case (md)
      2'd0: begin
        if (n >= 128) begin r = '0; st = |d; end
        else if (n != 0) begin r = d << n; st = |(d >> (128 - n)); end
        else r = d;
      end
      2'd1: begin
        if (n >= 128) begin r = '0; st = |d; end
        else if (n != 0) begin r = d >> n; st = |(d << (128 - n)); end
        else r = d;
      end
      2'd2: begin
        if (n >= 128) begin r = {128{d[127]}}; st = |d; end
        else if (n != 0) begin r = $signed(d) >>> n; st = |(d << (128 - n)); end
        else r = d;
      end
      default: begin
        r  = (m == 0) ? d : ((d << m) | (d >> (128 - m)));
        st = 1'b0;
      end
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / compare process.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {127'd0, bus.m_tvalid}, {127'd0, held_valid});
        check("stall_data", bus.m_tdata, held_data);
        check("stall_sticky", {127'd0, bus.m_sticky}, {127'd0, held_sticky});
        check("stall_user", {120'd0, bus.m_tuser}, {120'd0, held_user});
      end
      if (bus.m_tvalid && bus.m_tready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", {127'd0, bus.m_tvalid}, 128'd0);
        end else begin
          e = sb.pop_front();
          check("data", bus.m_tdata, e.data);
          check("sticky", {127'd0, bus.m_sticky}, {127'd0, e.sticky});
          check("user", {120'd0, bus.m_tuser}, {120'd0, e.user});
          if (e.has_lit) begin
            check("lit_data", bus.m_tdata, e.lit_data);
            check("lit_sticky", {127'd0, bus.m_sticky}, {127'd0, e.lit_sticky});
            check("latency", 128'(cyc - e.acc_cyc), 128'(NS));
          end
        end
      end
      if (bus.s_tvalid && bus.s_tready) begin
        ref_shift(bus.s_tdata, bus.s_shamt, bus.s_mode, e.data, e.sticky);
        e.user       = bus.s_tuser;
        e.has_lit    = cur_has_lit;
        e.lit_data   = cur_lit_data;
        e.lit_sticky = cur_lit_sticky;
        e.acc_cyc    = cyc;
        sb.push_back(e);
      end
      prev_stall  = bus.m_tvalid & ~bus.m_tready;
      held_valid  = bus.m_tvalid;
      held_data   = bus.m_tdata;
      held_sticky = bus.m_sticky;
      held_user   = bus.m_tuser;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (toggle) bus.m_tready = ~bus.m_tready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [127:0] d, input logic [7:0] sh, input logic [1:0] md,
                      input logic [7:0] u, input logic lit, input logic [127:0] lit_d,
                      input logic lit_st);
    logic ok;
    int   guard;
    guard          = 0;
    cur_has_lit    = lit;
    cur_lit_data   = lit_d;
    cur_lit_sticky = lit_st;
    bus.s_tvalid   = 1'b1;
    bus.s_tdata    = d;
    bus.s_shamt    = sh;
    bus.s_mode     = md;
    bus.s_tuser    = u;
    do begin
      @(negedge clk);
      ok = bus.s_tready;
      step();
      guard++;
    end while (!ok && guard < 100);
    if (!ok) check("accept_timeout", 128'd0, 128'd1);
    bus.s_tvalid = 1'b0;
    cur_has_lit  = 1'b0;
  endtask

  task automatic directed(input logic [127:0] d, input logic [7:0] sh, input logic [1:0] md,
                          input logic [7:0] u, input logic [127:0] lit_d, input logic lit_st);
    send(d, sh, md, u, 1'b1, lit_d, lit_st);
    idle(NS + 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int           n_acc;
    logic         full;
    int           out_before;
    logic [127:0] rnd;

    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_shamt  = '0;
    bus.s_mode   = '0;
    bus.s_tuser  = '0;
    bus.m_tready = 1'b1;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_tvalid", {127'd0, bus.m_tvalid}, 128'd0);
    check("rst_m_tdata", bus.m_tdata, 128'd0);
    check("rst_m_sticky", {127'd0, bus.m_sticky}, 128'd0);
    check("rst_m_tuser", {120'd0, bus.m_tuser}, 128'd0);
    check("rst_s_tready", {127'd0, bus.s_tready}, 128'd1);
    step();

    // Directed vectors with hand-computed results.
    directed(128'hF000_0000_0000_0000_0000_0000_0000_0001, 8'd4, 2'd0, 8'h01,
             128'h10, 1'b1);
    directed(128'h3, 8'd1, 2'd1, 8'h02, 128'h1, 1'b1);
    directed(128'h8000_0000_0000_0000_0000_0000_0000_1234, 8'd200, 2'd2, 8'h03,
             {128{1'b1}}, 1'b1);
    directed(128'h0, 8'd200, 2'd2, 8'h04, 128'h0, 1'b0);
    directed(128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'd129, 2'd3, 8'h05,
             128'h1, 1'b0);
    directed(128'h5, 8'd128, 2'd1, 8'h06, 128'h0, 1'b1);
    for (int m = 0; m < 4; m++) begin
      directed(128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 8'd0, 2'(m), 8'(8'h07 + m),
               128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, 1'b0);
    end

    // Back-to-back random stream with m_tready toggling 1010...
    bus.m_tready = 1'b1;
    toggle       = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      send(rnd, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 8'(8'h10 + i),
           1'b0, '0, 1'b0);
    end
    toggle       = 1'b0;
    bus.m_tready = 1'b1;
    idle(3 * NS);

    // Fill with the sink stalled: exactly NS accepts before s_tready drops.
    bus.m_tready = 1'b0;
    n_acc        = 0;
    full         = 1'b0;
    for (int i = 0; i < 12 && !full; i++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      bus.s_shamt  = 8'($urandom_range(0, 255));
      bus.s_mode   = 2'($urandom_range(0, 3));
      bus.s_tuser  = 8'(8'hA0 + i);
      @(negedge clk);
      if (bus.s_tready) n_acc++;
      else full = 1'b1;
      step();
    end
    check("fill_accepts", 128'(n_acc), 128'(NS));
    bus.m_tready = 1'b1;
    @(negedge clk);
    check("release_s_tready", {127'd0, bus.s_tready}, 128'd1);
    step();
    bus.m_tready = 1'b0;
    bus.s_tvalid = 1'b0;
    @(negedge clk);
    check("refill_s_tready", {127'd0, bus.s_tready}, 128'd0);
    step();
    bus.m_tready = 1'b1;
    idle(2 * NS);

    // Reset with five beats in flight.
    bus.m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 8'(i + 3), 2'(i % 4), 8'(8'hC0 + i),
           1'b0, '0, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_m_tvalid", {127'd0, bus.m_tvalid}, 128'd0);
    check("post_rst_s_tready", {127'd0, bus.s_tready}, 128'd1);
    out_before   = n_out;
    bus.m_tready = 1'b1;
    idle(2 * NS);
    check("no_stale_beats", 128'(n_out - out_before), 128'd0);

    check("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
